ex_hazard_ctrl: RTL and testbench
=================================

# ex_hazard_ctrl

Pipeline hazard controller for the 5-stage core. It sits between the ID stage and the EX stage. It shadows the destination and type of every in-flight instruction in EX, MEM and WB, and from that state it generates the operand-forwarding selects for EX, the load-use stall, and the branch flush. It also keeps saturating stall and flush counters for performance debug.

## Interface
- No parameters; register-file address width fixed at 5, opcode width at 6.
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_opcode  in  6  opcode of ID instruction: 000000 ADD, 100011 LW, 101011 SW, 000100 BEQ; anything else is a NOP.
- id_rs, id_rt  in  5 each  source register addresses of ID instruction.
- id_rd  in  5  destination register of ID instruction (already resolved by decode).
- ex_beq_taken  in  1  EX result bit 0; meaningful only while the EX shadow holds a valid BEQ.
- stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- flush  out  1  squash IF/ID and ID/EX (taken branch).
- fwd_rs_sel, fwd_rt_sel  out  2 each  EX operand source: 0 regfile/ID-EX, 1 MEM-stage ALU result, 2 WB write data, 3 never driven.
- state  out  2  FSM state: 0 RUN, 1 STALL, 2 FLUSH.
- stall_cnt, flush_cnt  out  16 each  saturating event counters.

## Operation
- Classification:
  - writes = ADD or LW, with dest ≠ 0.
  - reads_rs = ADD, LW, SW, BEQ.
  - reads_rt = ADD, SW, BEQ.
  - is_load = LW.
  - is_beq = BEQ.
- Shadow registers per stage (EX, MEM, WB): valid, writes, is_load, is_beq, dest, rs, rt.
- Each cycle MEM→WB and EX→MEM shift unconditionally.
- ID→EX loads the ID fields when none of stall, flush or id_valid=0 applies; otherwise EX loads a bubble (valid=0, writes=0).
- Load-use stall (combinational):
  - stall = id_valid & EX.valid & EX.is_load & EX.writes & ((reads_rs & id_rs==EX.dest) | (reads_rt & id_rt==EX.dest)) & ~flush.
- Flush (combinational): flush = EX.valid & EX.is_beq & ex_beq_taken.
  - Flush has priority over stall; stall is forced 0 whenever flush=1.
- Forwarding: computed from registered shadows only, never from inputs.
  - For EX.rs: sel=1 if MEM.valid & MEM.writes & MEM.dest==EX.rs & ~MEM.is_load.
  - Else sel=2 if WB.valid & WB.writes & WB.dest==EX.rs.
  - Else sel=0.
  - Same rule for EX.rt.
  - MEM takes priority over WB (youngest producer wins).
  - A source equal to 0 always gets sel=0.
  - MEM.is_load never forwards from MEM; the load-use stall guarantees the consumer reaches EX with the load in WB.
- FSM:
  - RUN→STALL on stall.
  - RUN→FLUSH on flush.
  - STALL→FLUSH on flush, else STALL→RUN.
  - FLUSH→STALL on stall, FLUSH→FLUSH on flush, else FLUSH→RUN.
  - STALL lasts exactly 1 cycle per load-use pair, because EX holds a bubble in the following cycle.
- Counters:
  - stall_cnt +1 on every cycle with stall=1; flush_cnt +1 on every cycle with flush=1.
  - Both saturate at 0xFFFF.

## Timing
- Reset (reset=0, asynchronous): all shadow valids=0, state=RUN, stall_cnt=flush_cnt=0.
  - Therefore stall=0, flush=0, fwd_*_sel=0 while in reset and in the first cycle after release.
- stall and flush are combinational from inputs plus registers, valid in the same cycle. They are consumed at the next rising edge.
- fwd_*_sel depend only on registers; they are valid from clk-to-q onward for the instruction currently in EX.
- Latency: a producer in EX at cycle n is in MEM at n+1 (sel=1 for the consumer in EX at n+1) and in WB at n+2 (sel=2).
- A load consumer sees exactly one bubble.
- Reset asserted mid-stall or mid-flush: all state clears immediately; no pending event survives release.

## Test plan
- Reset: hold reset=0 with arbitrary inputs → stall=0, flush=0, sels=0, cnts=0, state=0; after release the first ADD issues without stall.
- Back-to-back ADD r3=r1+r2 then ADD r4=r3+r3 → second instruction in EX has fwd_rs_sel=fwd_rt_sel=1. Insert one NOP between them → both sels=2. Insert two NOPs → both 0.
- LW r5 then ADD r6=r5+r1 → stall=1 for exactly one cycle, state 0→1→0, stall_cnt=1; consumer reaches EX with fwd_rs_sel=2.
- BEQ in EX with ex_beq_taken=1 while ID holds a LW-dependent ADD → flush=1 and stall=0 that cycle; flush_cnt=1; EX next cycle is a bubble (no forwarding), state=2.
- Writes to r0 (ADD rd=0, then a consumer of r0) → no stall and no forwarding; all sels 0.
- Force 65 540 consecutive load-use stalls (via a preload hook or long loop) → stall_cnt holds at 0xFFFF; pulse reset mid-stall → counters 0, state RUN.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl
//
// Hazard controller for the 5-stage core, placed between the ID and EX stages.
// It keeps a small shadow copy of the instruction in each of EX, MEM and WB.
// From those shadows it produces:
//   - the EX operand forwarding selects,
//   - the load-use stall,
//   - the taken-branch flush.
// It also keeps saturating stall/flush counters for performance debug.
//
// Ports
//   clk           core clock, rising edge
//   reset         asynchronous, active-low reset
//   id_valid      ID stage holds a real instruction
//   id_opcode     ID opcode (ADD 000000, LW 100011, SW 101011, BEQ 000100, else NOP)
//   id_rs, id_rt  ID source register addresses
//   id_rd         ID destination register (already resolved by decode)
//   ex_beq_taken  EX branch outcome, meaningful only while EX holds a valid BEQ
//   stall         hold PC and IF/ID, insert a bubble into ID/EX
//   flush         squash IF/ID and ID/EX
//   fwd_rs_sel    EX rs source: 0 regfile, 1 MEM ALU result, 2 WB write data
//   fwd_rt_sel    EX rt source, same encoding
//   state         0 RUN, 1 STALL, 2 FLUSH
//   stall_cnt     saturating count of stall cycles
//   flush_cnt     saturating count of flush cycles

module ex_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        ex_beq_taken,
    output logic        stall,
    output logic        flush,
    output logic [1:0]  fwd_rs_sel,
    output logic [1:0]  fwd_rt_sel,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;

    typedef struct packed {
        logic       valid;
        logic       writes;
        logic       is_load;
        logic       is_beq;
        logic [4:0] dest;
        logic [4:0] rs;
        logic [4:0] rt;
    } shadow_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    shadow_t ex_q, mem_q, wb_q;
    shadow_t id_entry, ex_d;
    logic    reads_rs, reads_rt;
    state_t  state_q, state_d;

    // Decode the ID instruction into the shadow fields.
    // A write to r0 is treated as no write at all, so it can never stall a
    // consumer or be forwarded.
    always_comb begin
        id_entry       = '0;
        reads_rs       = 1'b0;
        reads_rt       = 1'b0;
        id_entry.valid = 1'b1;
        id_entry.dest  = id_rd;
        id_entry.rs    = id_rs;
        id_entry.rt    = id_rt;
        unique case (id_opcode)
            OP_ADD: begin
                id_entry.writes = (id_rd != 5'd0);
                reads_rs        = 1'b1;
                reads_rt        = 1'b1;
            end
            OP_LW: begin
                id_entry.writes  = (id_rd != 5'd0);
                id_entry.is_load = 1'b1;
                reads_rs         = 1'b1;
            end
            OP_SW: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            OP_BEQ: begin
                id_entry.is_beq = 1'b1;
                reads_rs        = 1'b1;
                reads_rt        = 1'b1;
            end
            default: begin
                id_entry.valid = 1'b0;
            end
        endcase
    end

    // A taken branch in EX squashes everything younger.
    // Stall only matters when there is no flush, since the stalled consumer is
    // being thrown away anyway.
    always_comb begin
        flush = ex_q.valid & ex_q.is_beq & ex_beq_taken;
        stall = id_valid & ex_q.valid & ex_q.is_load & ex_q.writes &
                ((reads_rs & (id_rs == ex_q.dest)) |
                 (reads_rt & (id_rt == ex_q.dest))) & ~flush;
    end

    // A bubble is fully zeroed (not just valid/writes).
    // This leaves no stale source fields in EX to match a forwarding compare.
    always_comb begin
        ex_d = '0;
        if (id_valid && !stall && !flush) begin
            ex_d = id_entry;
        end
    end

    // Shadow pipeline.
    // MEM and WB shift every cycle; EX takes the ID instruction or a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // Forwarding select for one EX source, using registered state only.
    // The youngest producer (MEM) wins over WB.
    // A load in MEM never forwards, because its data only exists in WB.
    function automatic logic [1:0] fwd_select(input logic [4:0] src,
                                              input shadow_t    mem,
                                              input shadow_t    wb);
        logic [1:0] sel;
        sel = 2'd0;
        if (src != 5'd0) begin
            if (mem.valid && mem.writes && !mem.is_load && (mem.dest == src)) begin
                sel = 2'd1;
            end else if (wb.valid && wb.writes && (wb.dest == src)) begin
                sel = 2'd2;
            end
        end
        return sel;
    endfunction

    // An empty EX slot never requests forwarding.
    always_comb begin
        fwd_rs_sel = 2'd0;
        fwd_rt_sel = 2'd0;
        if (ex_q.valid) begin
            fwd_rs_sel = fwd_select(ex_q.rs, mem_q, wb_q);
            fwd_rt_sel = fwd_select(ex_q.rt, mem_q, wb_q);
        end
    end

    // Control FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // STALL cannot see a second stall, because EX holds a bubble in that cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (stall) begin
                    state_d = ST_STALL;
                end else if (flush) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_STALL: begin
                state_d = flush ? ST_FLUSH : ST_RUN;
            end
            ST_FLUSH: begin
                if (stall) begin
                    state_d = ST_STALL;
                end else if (flush) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign state = state_q;

    // Performance counters.
    // Each one counts the cycles in which its event is asserted and holds at
    // all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed testbench for ex_hazard_ctrl.
//
// Each step waits for a rising edge and then drives the ID inputs shortly
// after that edge. Checks are made once the combinational outputs have
// settled, so registered outputs show the state after that edge.

module tb_ex_hazard_ctrl;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_NOP = 6'b111111;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        ex_beq_taken;
    logic        stall;
    logic        flush;
    logic [1:0]  fwd_rs_sel;
    logic [1:0]  fwd_rt_sel;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int vectors;
    int miscompares;

    ex_hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_opcode    (id_opcode),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .ex_beq_taken (ex_beq_taken),
        .stall        (stall),
        .flush        (flush),
        .fwd_rs_sel   (fwd_rs_sel),
        .fwd_rt_sel   (fwd_rt_sel),
        .state        (state),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One pipeline step: wait for an edge, then present a new ID instruction.
    task automatic applyStimulus(input logic       valid,
                                 input logic [5:0] op,
                                 input logic [4:0] rs,
                                 input logic [4:0] rt,
                                 input logic [4:0] rd,
                                 input logic       taken);
        @(posedge clk);
        #2;
        id_valid     = valid;
        id_opcode    = op;
        id_rs        = rs;
        id_rt        = rt;
        id_rd        = rd;
        ex_beq_taken = taken;
        #1;
    endtask

    // Shorthand for a valid instruction with no taken branch.
    task automatic issue(input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd);
        applyStimulus(1'b1, op, rs, rt, rd, 1'b0);
    endtask

    // Shorthand for an empty ID slot.
    task automatic bubble();
        applyStimulus(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Check both forwarding selects at once.
    task automatic checkSels(input string tag, input logic [1:0] rs_exp,
                             input logic [1:0] rt_exp);
        checkOutput({tag, "_rs_sel"}, {14'd0, fwd_rs_sel}, {14'd0, rs_exp});
        checkOutput({tag, "_rt_sel"}, {14'd0, fwd_rt_sel}, {14'd0, rt_exp});
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b0;
        id_valid     = 1'b1;
        id_opcode    = OP_LW;
        id_rs        = 5'd5;
        id_rt        = 5'd5;
        id_rd        = 5'd5;
        ex_beq_taken = 1'b1;

        // Reset held low across edges with arbitrary inputs.
        #12;
        checkOutput("rst_stall", {15'd0, stall}, 16'd0);
        checkOutput("rst_flush", {15'd0, flush}, 16'd0);
        checkSels("rst", 2'd0, 2'd0);
        checkOutput("rst_state", {14'd0, state}, 16'd0);
        checkOutput("rst_stall_cnt", stall_cnt, 16'd0);
        checkOutput("rst_flush_cnt", flush_cnt, 16'd0);
        reset = 1'b1;

        // First ADD after release issues without stall.
        issue(OP_ADD, 5'd1, 5'd2, 5'd3);
        checkOutput("first_add_stall", {15'd0, stall}, 16'd0);
        checkSels("first_cycle", 2'd0, 2'd0);

        // Back-to-back dependency: forward from MEM.
        issue(OP_ADD, 5'd3, 5'd3, 5'd4);
        bubble();
        checkSels("b2b", 2'd1, 2'd1);

        // One NOP between producer and consumer: forward from WB.
        issue(OP_ADD, 5'd1, 5'd2, 5'd3);
        bubble();
        issue(OP_ADD, 5'd3, 5'd3, 5'd4);
        bubble();
        checkSels("gap1", 2'd2, 2'd2);

        // Two NOPs between: producer has retired, no forwarding.
        issue(OP_ADD, 5'd1, 5'd2, 5'd3);
        bubble();
        bubble();
        issue(OP_ADD, 5'd3, 5'd3, 5'd4);
        bubble();
        checkSels("gap2", 2'd0, 2'd0);

        // Two producers of r3 in MEM and WB: the younger one (MEM) wins.
        issue(OP_ADD, 5'd1, 5'd2, 5'd3);
        issue(OP_ADD, 5'd2, 5'd1, 5'd3);
        issue(OP_ADD, 5'd3, 5'd12, 5'd4);
        bubble();
        checkSels("mem_prio", 2'd1, 2'd0);

        // Load-use: exactly one stall cycle, then the consumer forwards from WB.
        issue(OP_LW, 5'd1, 5'd0, 5'd5);
        checkOutput("lw_issue_stall", {15'd0, stall}, 16'd0);
        issue(OP_ADD, 5'd5, 5'd1, 5'd6);
        checkOutput("lu_stall", {15'd0, stall}, 16'd1);
        checkOutput("lu_state0", {14'd0, state}, 16'd0);
        issue(OP_ADD, 5'd5, 5'd1, 5'd6);
        checkOutput("lu_stall_after", {15'd0, stall}, 16'd0);
        checkOutput("lu_state1", {14'd0, state}, 16'd1);
        checkOutput("lu_stall_cnt", stall_cnt, 16'd1);
        issue(OP_ADD, 5'd1, 5'd2, 5'd9);
        checkOutput("lu_state2", {14'd0, state}, 16'd0);
        checkSels("lu_consumer", 2'd2, 2'd0);

        // Taken BEQ in EX squashes a dependent ADD in ID; flush wins.
        issue(OP_BEQ, 5'd1, 5'd2, 5'd0);
        applyStimulus(1'b1, OP_ADD, 5'd9, 5'd9, 5'd7, 1'b0);
        ex_beq_taken = 1'b1;
        #1;
        checkOutput("br_flush", {15'd0, flush}, 16'd1);
        checkOutput("br_stall", {15'd0, stall}, 16'd0);
        checkOutput("br_flush_cnt0", flush_cnt, 16'd0);
        bubble();
        checkOutput("br_flush_after", {15'd0, flush}, 16'd0);
        checkOutput("br_state", {14'd0, state}, 16'd2);
        checkOutput("br_flush_cnt1", flush_cnt, 16'd1);
        checkSels("br_bubble", 2'd0, 2'd0);
        bubble();
        checkOutput("br_state_back", {14'd0, state}, 16'd0);

        // Writes to r0 never stall and never forward.
        issue(OP_ADD, 5'd1, 5'd2, 5'd0);
        issue(OP_ADD, 5'd0, 5'd0, 5'd10);
        bubble();
        checkSels("r0_add", 2'd0, 2'd0);
        issue(OP_LW, 5'd1, 5'd0, 5'd0);
        issue(OP_SW, 5'd0, 5'd0, 5'd0);
        checkOutput("r0_lw_stall", {15'd0, stall}, 16'd0);
        bubble();
        checkSels("r0_lw", 2'd0, 2'd0);
        checkOutput("r0_stall_cnt", stall_cnt, 16'd1);

        // Saturation: preload the stall counter just below all-ones.
        // The counter then sees further stalls at its limit.
        issue(OP_LW, 5'd1, 5'd0, 5'd5);
        issue(OP_ADD, 5'd5, 5'd1, 5'd6);
        force dut.stall_cnt = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.stall_cnt;
        for (int i = 0; i < 3; i++) begin
            issue(OP_LW, 5'd1, 5'd0, 5'd5);
            issue(OP_ADD, 5'd5, 5'd1, 5'd6);
        end
        checkOutput("sat_stall", {15'd0, stall}, 16'd1);
        checkOutput("sat_cnt", stall_cnt, 16'hFFFF);
        issue(OP_ADD, 5'd5, 5'd1, 5'd6);
        checkOutput("sat_state", {14'd0, state}, 16'd1);
        checkOutput("sat_cnt_hold", stall_cnt, 16'hFFFF);

        // Asynchronous reset while in STALL clears everything at once.
        reset = 1'b0;
        #1;
        checkOutput("midrst_state", {14'd0, state}, 16'd0);
        checkOutput("midrst_stall_cnt", stall_cnt, 16'd0);
        checkOutput("midrst_flush_cnt", flush_cnt, 16'd0);
        checkOutput("midrst_stall", {15'd0, stall}, 16'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        issue(OP_ADD, 5'd5, 5'd1, 5'd6);
        checkOutput("post_rst_stall", {15'd0, stall}, 16'd0);
        checkSels("post_rst", 2'd0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
